// File: rtl/csr_machine_if.sv
// Access, trap/return and interrupt bundle between execute, fetch and csr_machine.
interface csr_machine_if #(
  parameter int DATA_WIDTH = 32
);
  logic [11:0]           csr_addr;
  logic [DATA_WIDTH-1:0] csr_wdata;
  logic [1:0]            csr_op;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  csr_illegal;
  logic                  trap;
  logic                  trap_irq;
  logic [4:0]            trap_code;
  logic [DATA_WIDTH-1:0] trap_value;
  logic [DATA_WIDTH-1:0] trap_pc;
  logic                  mret;
  logic                  instret;
  logic                  irq_sw;
  logic                  irq_timer;
  logic                  irq_ext;
  logic                  irq_pending;
  logic                  redirect_valid;
  logic [DATA_WIDTH-1:0] redirect_pc;

  modport master (
    output csr_addr, csr_wdata, csr_op, trap, trap_irq, trap_code, trap_value, trap_pc,
           mret, instret, irq_sw, irq_timer, irq_ext,
    input  csr_rdata, csr_illegal, irq_pending, redirect_valid, redirect_pc
  );

  modport slave (
    input  csr_addr, csr_wdata, csr_op, trap, trap_irq, trap_code, trap_value, trap_pc,
           mret, instret, irq_sw, irq_timer, irq_ext,
    output csr_rdata, csr_illegal, irq_pending, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/csr_machine.sv
// Machine-mode CSR unit: WARL CSRs, trap entry/mret redirect, interrupt pending, counters.
// Optional feature macro: CSR_COUNTERS_EN enables mcycle/minstret (and h halves on RV32).
module csr_machine #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] HART_ID     = '0,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0
) (
  input logic          clk,
  input logic          rst_n,
  csr_machine_if.slave bus
);
  localparam int XLEN = DATA_WIDTH;
  localparam logic [11:0] A_MVENDORID = 12'hF11, A_MARCHID = 12'hF12, A_MIMPID = 12'hF13;
  localparam logic [11:0] A_MHARTID = 12'hF14, A_MSTATUS = 12'h300, A_MISA = 12'h301;
  localparam logic [11:0] A_MIE = 12'h304, A_MTVEC = 12'h305, A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343;
  localparam logic [11:0] A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;
  localparam logic [1:0]  MXL = (XLEN == 64) ? 2'd2 : 2'd1;

  logic            r_mstatus_mie, r_mstatus_mpie;
  logic [2:0]      r_mie;
  logic [XLEN-1:0] r_mtvec, r_mepc, r_mscratch, r_mtval;
  logic            r_mcause_irq;
  logic [4:0]      r_mcause_code;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [XLEN-1:0] w_rdata, w_new, w_mstatus, w_misa, w_mie_rd, w_mip, w_mcause, w_trap_target;
  logic            w_mapped, w_ro, w_illegal, w_wr_en;
  logic            w_unused;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle, r_minstret;
  logic [31:0] w_hi_data;
  logic        w_cyc_lo_wr, w_cyc_hi_wr, w_ins_lo_wr, w_ins_hi_wr;
  assign w_unused = ^bus.trap_pc[1:0];
`else
  assign w_unused = ^{bus.trap_pc[1:0], bus.instret};
`endif

  // Read mux with mapped/read-only decode; field packing of the narrow registers.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mstatus_mpie;
    w_mstatus[3]     = r_mstatus_mie;
    w_misa           = '0;
    w_misa[XLEN-1 -: 2] = MXL;
    w_misa[8]        = 1'b1;
    w_mie_rd         = '0;
    w_mie_rd[3]      = r_mie[0];
    w_mie_rd[7]      = r_mie[1];
    w_mie_rd[11]     = r_mie[2];
    w_mip            = '0;
    w_mip[3]         = bus.irq_sw;
    w_mip[7]         = bus.irq_timer;
    w_mip[11]        = bus.irq_ext;
    w_mcause         = '0;
    w_mcause[XLEN-1] = r_mcause_irq;
    w_mcause[4:0]    = r_mcause_code;
    w_rdata          = '0;
    w_mapped         = 1'b1;
    w_ro             = 1'b0;
    case (bus.csr_addr)
      A_MVENDORID, A_MARCHID, A_MIMPID: w_ro = 1'b1;
      A_MHARTID:  begin w_rdata = HART_ID; w_ro = 1'b1; end
      A_MISA:     begin w_rdata = w_misa;  w_ro = 1'b1; end
      A_MIP:      begin w_rdata = w_mip;   w_ro = 1'b1; end
      A_MSTATUS:  w_rdata = w_mstatus;
      A_MIE:      w_rdata = w_mie_rd;
      A_MTVEC:    w_rdata = r_mtvec;
      A_MSCRATCH: w_rdata = r_mscratch;
      A_MEPC:     w_rdata = r_mepc;
      A_MCAUSE:   w_rdata = w_mcause;
      A_MTVAL:    w_rdata = r_mtval;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:   w_rdata = r_mcycle[XLEN-1:0];
      A_MINSTRET: w_rdata = r_minstret[XLEN-1:0];
      A_MCYCLEH:  if (XLEN == 32) w_rdata = XLEN'(r_mcycle[63:32]);   else w_mapped = 1'b0;
      A_MINSTRETH: if (XLEN == 32) w_rdata = XLEN'(r_minstret[63:32]); else w_mapped = 1'b0;
`endif
      default:    w_mapped = 1'b0;
    endcase
  end

  // Operand for write/set/clear, computed from the current readable value.
  always_comb begin
    case (bus.csr_op)
      2'b01:   w_new = bus.csr_wdata;
      2'b10:   w_new = w_rdata | bus.csr_wdata;
      2'b11:   w_new = w_rdata & ~bus.csr_wdata;
      default: w_new = bus.csr_wdata;
    endcase
  end

  assign w_illegal = !w_mapped || ((bus.csr_op != 2'b00) && w_ro);
  // trap and mret both win over a same-cycle CSR op, which is then dropped
  assign w_wr_en   = (bus.csr_op != 2'b00) && !w_illegal && !bus.trap && !bus.mret;
  assign w_trap_target = {r_mtvec[XLEN-1:2], 2'b00} +
      (((r_mtvec[1:0] == 2'b01) && bus.trap_irq) ? XLEN'({bus.trap_code, 2'b00}) : '0);

  // Architectural CSR state: trap entry, mret, then software writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 3'b000;
      r_mtvec        <= MTVEC_RESET;
      r_mepc         <= '0;
      r_mscratch     <= '0;
      r_mtval        <= '0;
      r_mcause_irq   <= 1'b0;
      r_mcause_code  <= 5'd0;
    end else if (bus.trap) begin
      r_mepc         <= {bus.trap_pc[XLEN-1:2], 2'b00};
      r_mcause_irq   <= bus.trap_irq;
      r_mcause_code  <= bus.trap_code;
      r_mtval        <= bus.trap_value;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (bus.mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_wr_en) begin
      case (bus.csr_addr)
        A_MSTATUS:  begin r_mstatus_mie <= w_new[3]; r_mstatus_mpie <= w_new[7]; end
        A_MIE:      r_mie <= {w_new[11], w_new[7], w_new[3]};
        A_MTVEC:    r_mtvec <= {w_new[XLEN-1:2], w_new[1] ? r_mtvec[1:0] : w_new[1:0]};
        A_MSCRATCH: r_mscratch <= w_new;
        A_MEPC:     r_mepc <= {w_new[XLEN-1:2], 2'b00};
        A_MCAUSE:   begin r_mcause_irq <= w_new[XLEN-1]; r_mcause_code <= w_new[4:0]; end
        A_MTVAL:    r_mtval <= w_new;
        default:    ;
      endcase
    end
  end

  // Fetch redirect: one-cycle pulse, target held between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= bus.trap || bus.mret;
      if (bus.trap)      r_redirect_pc <= w_trap_target;
      else if (bus.mret) r_redirect_pc <= r_mepc;
    end
  end

`ifdef CSR_COUNTERS_EN
  generate
    if (XLEN == 64) begin : g_hi64
      assign w_hi_data = w_new[63:32];
    end else begin : g_hi32
      assign w_hi_data = w_new[31:0];
    end
  endgenerate

  assign w_cyc_lo_wr = w_wr_en && (bus.csr_addr == A_MCYCLE);
  assign w_cyc_hi_wr = w_wr_en && ((bus.csr_addr == A_MCYCLEH) || ((XLEN == 64) && (bus.csr_addr == A_MCYCLE)));
  assign w_ins_lo_wr = w_wr_en && (bus.csr_addr == A_MINSTRET);
  assign w_ins_hi_wr = w_wr_en && ((bus.csr_addr == A_MINSTRETH) || ((XLEN == 64) && (bus.csr_addr == A_MINSTRET)));

  // Free-running counters; a write to either half replaces it and skips that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_cyc_lo_wr || w_cyc_hi_wr) begin
        if (w_cyc_lo_wr) r_mcycle[31:0]  <= w_new[31:0];
        if (w_cyc_hi_wr) r_mcycle[63:32] <= w_hi_data;
      end else begin
        r_mcycle <= r_mcycle + 64'd1;
      end
      if (w_ins_lo_wr || w_ins_hi_wr) begin
        if (w_ins_lo_wr) r_minstret[31:0]  <= w_new[31:0];
        if (w_ins_hi_wr) r_minstret[63:32] <= w_hi_data;
      end else if (bus.instret) begin
        r_minstret <= r_minstret + 64'd1;
      end
    end
  end
`endif

  assign bus.csr_rdata      = w_rdata;
  assign bus.csr_illegal    = w_illegal;
  assign bus.irq_pending    = r_mstatus_mie && |(r_mie & {bus.irq_ext, bus.irq_timer, bus.irq_sw});
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_csr_machine.sv
// Self-checking bench for csr_machine (RV32, HART_ID=5): vector table plus trap/mret/counter sequences.
module tb_csr_machine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic        exp_ill;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd_q[$];
  logic [31:0] redir_q[$];

  csr_machine_if #(.DATA_WIDTH(32)) bus();

  csr_machine #(.DATA_WIDTH(32), .HART_ID(32'd5), .MTVEC_RESET(32'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [11:0] addr, input logic [1:0] op,
                              input logic [31:0] wdata, input logic exp_ill, input logic [31:0] exp_rd);
    vec_t v;
    v.name = name; v.addr = addr; v.op = op; v.wdata = wdata; v.exp_ill = exp_ill; v.exp_rd = exp_rd;
    return v;
  endfunction

  // Drive one access at negedge, check illegal flag, then read back after the edge.
  task automatic do_op(input string name, input logic [11:0] addr, input logic [1:0] op,
                       input logic [31:0] wdata, input logic exp_ill, input logic [31:0] exp_rd);
    @(negedge clk);
    bus.csr_addr = addr; bus.csr_op = op; bus.csr_wdata = wdata;
    rd_q.push_back(exp_rd);
    #1;
    chk({name, "_ill"}, 32'(bus.csr_illegal), 32'(exp_ill));
    @(posedge clk);
    #1;
    bus.csr_op = 2'b00;
    #1;
    chk({name, "_rd"}, bus.csr_rdata, rd_q.pop_front());
  endtask

  task automatic pop_redirect(input string name);
    n_tests++;
    if (bus.redirect_valid !== 1'b1 || redir_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: redirect_valid got %b expected 1", name, bus.redirect_valid);
      if (redir_q.size() != 0) void'(redir_q.pop_front());
    end else begin
      n_tests--;
      chk(name, bus.redirect_pc, redir_q.pop_front());
    end
  endtask

  // Wait (bounded) for each expected redirect pulse, then check pulse end and target hold.
  task automatic drain_redirect(input string name);
    int budget = 8;
    logic [31:0] last = 32'd0;
    while (redir_q.size() != 0 && budget > 0) begin
      if (bus.redirect_valid) begin
        last = redir_q[0];
        chk(name, bus.redirect_pc, redir_q.pop_front());
      end
      budget--;
      @(negedge clk);
    end
    if (redir_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no pulse expected redirect 0x%08h", name, redir_q[0]);
      redir_q.delete();
    end
    chk({name, "_pulse_end"}, 32'(bus.redirect_valid), 32'd0);
    chk({name, "_hold"}, bus.redirect_pc, last);
  endtask

  task automatic drive_trap(input logic irq, input logic [4:0] code, input logic [31:0] pc,
                            input logic [31:0] val);
    bus.trap = 1'b1; bus.trap_irq = irq; bus.trap_code = code; bus.trap_pc = pc; bus.trap_value = val;
  endtask

  initial begin
    bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0; bus.csr_op = 2'b00;
    bus.trap = 1'b0; bus.trap_irq = 1'b0; bus.trap_code = 5'd0; bus.trap_value = 32'd0;
    bus.trap_pc = 32'd0; bus.mret = 1'b0; bus.instret = 1'b0;
    bus.irq_sw = 1'b0; bus.irq_timer = 1'b0; bus.irq_ext = 1'b1;

    vecs.push_back(mk("misa",        12'h301, 2'b00, 32'h0,        1'b0, 32'h40000100));
    vecs.push_back(mk("mstatus_rst", 12'h300, 2'b00, 32'h0,        1'b0, 32'h00001800));
    vecs.push_back(mk("unmapped",    12'h7C0, 2'b00, 32'h0,        1'b1, 32'h0));
    vecs.push_back(mk("mstatus_wr",  12'h300, 2'b01, 32'h0000FFFF, 1'b0, 32'h00001888));
    vecs.push_back(mk("mstatus_clr", 12'h300, 2'b11, 32'h00000008, 1'b0, 32'h00001880));
    vecs.push_back(mk("mhartid_wr",  12'hF14, 2'b01, 32'hFFFFFFFF, 1'b1, 32'h00000005));
    vecs.push_back(mk("mvendorid",   12'hF11, 2'b10, 32'h1,        1'b1, 32'h0));
    vecs.push_back(mk("mip_wr",      12'h344, 2'b01, 32'hFFFFFFFF, 1'b1, 32'h0));
    vecs.push_back(mk("mie_wr",      12'h304, 2'b01, 32'hFFFFFFFF, 1'b0, 32'h00000888));
    vecs.push_back(mk("mie_clr",     12'h304, 2'b11, 32'h00000088, 1'b0, 32'h00000800));
    vecs.push_back(mk("mtvec_wr",    12'h305, 2'b01, 32'h00001001, 1'b0, 32'h00001001));
    vecs.push_back(mk("mtvec_mode3", 12'h305, 2'b01, 32'h00002003, 1'b0, 32'h00002001));
    vecs.push_back(mk("mtvec_wr2",   12'h305, 2'b01, 32'h00001001, 1'b0, 32'h00001001));
    vecs.push_back(mk("mepc_wr",     12'h341, 2'b01, 32'h00000123, 1'b0, 32'h00000120));
    vecs.push_back(mk("mcause_wr",   12'h342, 2'b01, 32'hFFFFFFFF, 1'b0, 32'h8000001F));
    vecs.push_back(mk("mscratch_wr", 12'h340, 2'b01, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk("mscratch_set",12'h340, 2'b10, 32'h00000010, 1'b0, 32'hDEADBEFF));
    vecs.push_back(mk("mtval_wr",    12'h343, 2'b01, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5));
`ifndef CSR_COUNTERS_EN
    vecs.push_back(mk("mcycle_absent",    12'hB00, 2'b00, 32'h0, 1'b1, 32'h0));
    vecs.push_back(mk("minstreth_absent", 12'hB82, 2'b01, 32'h7, 1'b1, 32'h0));
`endif
    vecs.push_back(mk("mstatus_mie", 12'h300, 2'b01, 32'h00000008, 1'b0, 32'h00001808));

    repeat (3) @(negedge clk);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_irq_pending", 32'(bus.irq_pending), 32'd0);
    rst_n = 1'b1;
    bus.irq_ext = 1'b0;

    foreach (vecs[i]) do_op(vecs[i].name, vecs[i].addr, vecs[i].op, vecs[i].wdata,
                            vecs[i].exp_ill, vecs[i].exp_rd);

    // Interrupt pending with mie=0x800, MIE=1.
    @(negedge clk); bus.irq_ext = 1'b1; #1;
    chk("irq_ext_pending", 32'(bus.irq_pending), 32'd1);
    bus.irq_timer = 1'b1;
    do_op("mip_rd", 12'h344, 2'b00, 32'h0, 1'b0, 32'h00000880);
    @(negedge clk); bus.irq_ext = 1'b0; #1;
    chk("irq_timer_masked", 32'(bus.irq_pending), 32'd0);
    bus.irq_timer = 1'b0;

    // Vectored interrupt trap with a same-cycle mscratch write that must be dropped.
    @(negedge clk);
    drive_trap(1'b1, 5'd7, 32'h206, 32'h55);
    bus.csr_addr = 12'h340; bus.csr_op = 2'b01; bus.csr_wdata = 32'h1111;
    redir_q.push_back(32'h101C);
    @(negedge clk);
    bus.trap = 1'b0; bus.csr_op = 2'b00;
    drain_redirect("trap_vec");
    do_op("trap_mepc",     12'h341, 2'b00, 32'h0, 1'b0, 32'h00000204);
    do_op("trap_mcause",   12'h342, 2'b00, 32'h0, 1'b0, 32'h80000007);
    do_op("trap_mtval",    12'h343, 2'b00, 32'h0, 1'b0, 32'h00000055);
    do_op("trap_mstatus",  12'h300, 2'b00, 32'h0, 1'b0, 32'h00001880);
    do_op("trap_mscratch", 12'h340, 2'b00, 32'h0, 1'b0, 32'hDEADBEFF);

    // mret restores MIE from MPIE and returns to mepc.
    @(negedge clk); bus.mret = 1'b1; redir_q.push_back(32'h204);
    @(negedge clk); bus.mret = 1'b0;
    drain_redirect("mret");
    do_op("mret_mstatus", 12'h300, 2'b00, 32'h0, 1'b0, 32'h00001888);

    @(negedge clk); bus.irq_ext = 1'b1; #1;
    chk("irq_pending_on", 32'(bus.irq_pending), 32'd1);
    do_op("mie_off", 12'h300, 2'b11, 32'h8, 1'b0, 32'h00001880);
    chk("irq_pending_off", 32'(bus.irq_pending), 32'd0);
    bus.irq_ext = 1'b0;

    // Back-to-back traps: exception (base only) then vectored interrupt.
    @(negedge clk);
    drive_trap(1'b0, 5'd2, 32'h302, 32'h11);
    redir_q.push_back(32'h1000);
    @(negedge clk);
    pop_redirect("b2b_first");
    drive_trap(1'b1, 5'd11, 32'h402, 32'h22);
    redir_q.push_back(32'h102C);
    @(negedge clk);
    bus.trap = 1'b0;
    drain_redirect("b2b_second");
    do_op("b2b_mepc",    12'h341, 2'b00, 32'h0, 1'b0, 32'h00000400);
    do_op("b2b_mcause",  12'h342, 2'b00, 32'h0, 1'b0, 32'h8000000B);
    do_op("b2b_mtval",   12'h343, 2'b00, 32'h0, 1'b0, 32'h00000022);
    do_op("b2b_mstatus", 12'h300, 2'b00, 32'h0, 1'b0, 32'h00001800);

    // Direct mode: interrupt goes to BASE regardless of code.
    do_op("mtvec_direct", 12'h305, 2'b01, 32'h00003000, 1'b0, 32'h00003000);
    @(negedge clk); drive_trap(1'b1, 5'd3, 32'h501, 32'h0); redir_q.push_back(32'h3000);
    @(negedge clk); bus.trap = 1'b0;
    drain_redirect("trap_direct");
    @(negedge clk); bus.mret = 1'b1; redir_q.push_back(32'h500);
    @(negedge clk); bus.mret = 1'b0;
    drain_redirect("mret_direct");

`ifdef CSR_COUNTERS_EN
    @(negedge clk); bus.csr_addr = 12'hB00; bus.csr_op = 2'b01; bus.csr_wdata = 32'hFFFFFFFF;
    @(negedge clk); bus.csr_addr = 12'hB80; bus.csr_op = 2'b01; bus.csr_wdata = 32'h0;
    @(negedge clk); bus.csr_op = 2'b00; bus.csr_addr = 12'hB00; #1;
    chk("mcycle_held", bus.csr_rdata, 32'hFFFFFFFF);
    @(negedge clk); bus.csr_addr = 12'hB80; #1;
    chk("mcycleh_wrap", bus.csr_rdata, 32'h1);
    bus.csr_addr = 12'hB00; #1;
    chk("mcycle_wrap", bus.csr_rdata, 32'h0);
    @(negedge clk); bus.csr_addr = 12'hB02; bus.csr_op = 2'b01; bus.csr_wdata = 32'h0;
    @(negedge clk); bus.csr_addr = 12'hB82; bus.csr_op = 2'b01; bus.csr_wdata = 32'h0;
    @(negedge clk); bus.csr_op = 2'b00; bus.instret = 1'b1;
    repeat (5) @(negedge clk);
    bus.instret = 1'b0; bus.csr_addr = 12'hB02; #1;
    chk("minstret_5", bus.csr_rdata, 32'd5);
    bus.csr_addr = 12'hB82; #1;
    chk("minstreth_0", bus.csr_rdata, 32'd0);
`endif

    // Asynchronous reset in the middle of a redirect pulse.
    @(negedge clk); drive_trap(1'b0, 5'd1, 32'h700, 32'h0);
    @(negedge clk); bus.trap = 1'b0;
    chk("pre_rst_valid", 32'(bus.redirect_valid), 32'd1);
    rst_n = 1'b0; bus.csr_addr = 12'h305; #1;
    chk("midrst_valid", 32'(bus.redirect_valid), 32'd0);
    chk("midrst_pc", bus.redirect_pc, 32'd0);
    chk("midrst_mtvec", bus.csr_rdata, 32'd0);
    bus.csr_addr = 12'h341; #1;
    chk("midrst_mepc", bus.csr_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_machine.md
# csr_machine

Machine-mode CSR unit for the core, successor to the flat CSR array. It implements only the architecturally mapped M-mode CSRs with WARL field masking, and flags illegal accesses. It handles trap entry, `mret` return and direct/vectored `mtvec`, and provides interrupt pending/enable logic plus 64-bit cycle/instret counters. It sits beside the execute stage: execute drives the access port, and the trap/return redirect goes to the fetch PC mux.

## Interface
- `DATA_WIDTH`, 32: XLEN; 32 or 64 only.
- `HART_ID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 0: reset value of `mtvec` (mode bits included).
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in DATA_WIDTH: write/set/clear operand.
- `csr_op` in 2: 00 none, 01 write, 10 set, 11 clear.
- `csr_rdata` out DATA_WIDTH: combinational read of `csr_addr`; 0 when unmapped.
- `csr_illegal` out 1: combinational; address unmapped, or op≠00 to a read-only CSR.
- `trap` in 1: trap-entry pulse.
- `trap_irq` in 1: trap is an interrupt.
- `trap_code` in 5: exception/interrupt code.
- `trap_value` in DATA_WIDTH: value for `mtval`.
- `trap_pc` in DATA_WIDTH: value for `mepc`.
- `mret` in 1: return pulse.
- `instret` in 1: one instruction retired this cycle.
- `irq_sw`, `irq_timer`, `irq_ext` in 1 each: level interrupt sources.
- `irq_pending` out 1: `mstatus.MIE & |(mie & mip)`.
- `redirect_valid` out 1: one-cycle pulse; `redirect_pc` is valid.
- `redirect_pc` out DATA_WIDTH: trap target or `mepc`.

## Operation
- Read-only CSRs:
  - `mvendorid`, `marchid`, `mimpid` return 0.
  - `mhartid` returns HART_ID.
  - `misa` returns MXL (1 for 32, 2 for 64) in the top two bits, with bit 8 (I) set.
  - `mip` (0x344) returns bit 3 = irq_sw, bit 7 = irq_timer, bit 11 = irq_ext.
- `mstatus`: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11; all other bits read 0.
- `mie`: bits 3, 7, 11 are writable; all others read 0.
- `mtvec`: BASE is [DATA_WIDTH-1:2] and MODE is [1:0].
  - A write with MODE 2 or 3 updates BASE but keeps the old MODE.
- `mepc`: bits [1:0] are forced to 0 on every write, including trap entry.
- `mscratch`, `mtval`: fully writable.
- `mcause`: writable. Bit DATA_WIDTH-1 holds the interrupt flag, [4:0] the code, and the rest read 0.
- Counters: `mcycle`/`minstret` (0xB00/0xB02) expose bits [31:0] in 32-bit mode, with high halves at 0xB80/0xB82. In 64-bit mode they expose the full 64 bits and the `h` addresses are unmapped.
- Set/clear compute from the current value, then apply the WARL mask.
- Illegal accesses change no state.
- Priority per cycle: `trap` > `mret` > CSR op.
  - A CSR op that loses to trap or mret is dropped.
  - Counters still count in that cycle.
- Trap entry:
  - `mepc` ← trap_pc, `mcause` ← {trap_irq, code}, `mtval` ← trap_value.
  - MPIE ← MIE, MIE ← 0.
  - `redirect_pc` ← BASE<<2, plus code×4 when MODE=1 and trap_irq=1.
- `mret`: MIE ← MPIE, MPIE ← 1, `redirect_pc` ← `mepc`.
- Counters:
  - `mcycle` increments by 1 every cycle.
  - `minstret` increments by 1 when `instret` is high.
  - Both are 64 bits and wrap from all-ones to 0.
  - A CSR write to either half of a counter replaces that half in that cycle, and the increment is suppressed for that cycle.

## Timing
- Reads are zero-latency combinational. Writes are visible from the next cycle.
- `redirect_valid`/`redirect_pc` are registered and assert in the cycle after `trap` or `mret`, for exactly one cycle.
- `redirect_pc` holds its value between pulses.
- The `mtvec` value used for trap entry is the value before any same-cycle CSR write, because the CSR op is dropped.
- Back-to-back `trap` in consecutive cycles: each produces a pulse, and the last one wins the CSR state.
- `irq_pending` is combinational from registered state and the raw irq inputs.
- Reset (async, any time, including mid-redirect):
  - `mstatus` MIE=0, MPIE=0; `mie`=0.
  - `mepc`, `mcause`, `mtval`, `mscratch` = 0; counters = 0.
  - `mtvec` = MTVEC_RESET.
  - `redirect_valid`=0, `redirect_pc`=0.
  - `irq_pending` is 0 because MIE=0.

## Configuration
- `CSR_COUNTERS_EN` defined: `mcycle`/`minstret` and their `h` halves are implemented as above.
- Not defined: counter registers are absent. 0xB00, 0xB02, 0xB80 and 0xB82 are unmapped: `csr_illegal`=1 and read 0. `instret` is ignored.

## Test plan
- Reset, then read `misa` (DATA_WIDTH=32) and `mstatus` -> 0x40000100 and 0x00001800; `csr_illegal`=0. Read 0x7C0 -> `csr_illegal`=1, rdata 0.
- Write 0x0000FFFF to `mstatus`, then clear 0x8 -> reads 0x1888, then 0x1880. Write 0xFFFFFFFF to `mhartid` -> `csr_illegal`=1 and value unchanged.
- `mtvec`=0x1001, `mstatus`.MIE=1; trap_irq=1, code=7, trap_pc=0x206 -> next cycle `redirect_valid`=1, `redirect_pc`=0x101C; `mepc`=0x204, `mcause`=0x80000007, MIE=0, MPIE=1.
- `mret` -> next cycle `redirect_pc`=0x204, MIE=1, MPIE=1. `trap` and a CSR write to `mscratch` in the same cycle -> `mscratch` unchanged.
- With `CSR_COUNTERS_EN`: write `mcycle`=0xFFFFFFFF and `mcycleh`=0 -> two cycles later `mcycleh`=1, `mcycle`=0. With instret held high for 5 cycles -> `minstret`=5.
- `mie`=0x800, MIE=1, assert irq_ext -> `irq_pending`=1 in the same cycle. Deassert MIE -> `irq_pending`=0.
